// File: rtl/cache_refill_ctrl.sv
// Miss handler between a core read port and a two-way cache.
// On a hit the lookup data goes straight back to the core. On a miss the
// block is fetched from backing memory, written into the cache and forwarded
// to the core. Only one read is in flight at a time. Saturating hit and miss
// counters are kept. Every output is driven from a register.
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 32,
  parameter int TIMEOUT    = 255,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  core_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  output logic                  core_busy_o,
  output logic                  core_rvalid_o,
  output logic [BLOCK_SIZE-1:0] core_rdata_o,
  output logic                  core_err_o,
  output logic                  cache_rd_en_o,
  output logic [ADDR_WIDTH-1:0] cache_rd_addr_o,
  input  logic                  cache_rd_valid_i,
  input  logic                  cache_miss_i,
  input  logic [BLOCK_SIZE-1:0] cache_rd_data_i,
  output logic                  cache_wr_en_o,
  output logic [ADDR_WIDTH-1:0] cache_wr_addr_o,
  output logic [BLOCK_SIZE-1:0] cache_wr_data_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [BLOCK_SIZE-1:0] mem_resp_data_i,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

  localparam int OFF_BITS = $clog2(BLOCK_SIZE / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_FILL
  } state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  rvalid_q;
  logic [BLOCK_SIZE-1:0] rdata_q;
  logic                  err_q;
  logic                  cache_rd_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] blk_q;
  logic                  cache_wr_en_q;
  logic [BLOCK_SIZE-1:0] fill_q;
  logic                  mem_req_valid_q;
  logic [TW-1:0]         tcnt_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q;
  logic [CNT_WIDTH-1:0]  miss_cnt_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_d;

  // Saturating increments of the hit/miss counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_cnt_q != '1)  hit_cnt_d  = hit_cnt_q + CNT_WIDTH'(1);
    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
  end

  // Request sequencing FSM with registered outputs.
  // The lookup strobe is high during the first LOOKUP cycle; the cache answer
  // is only sampled once the strobe has dropped, i.e. the cycle after it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b0;
      rvalid_q        <= 1'b0;
      rdata_q         <= '0;
      err_q           <= 1'b0;
      cache_rd_en_q   <= 1'b0;
      addr_q          <= '0;
      blk_q           <= '0;
      cache_wr_en_q   <= 1'b0;
      fill_q          <= '0;
      mem_req_valid_q <= 1'b0;
      tcnt_q          <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      rvalid_q      <= 1'b0;
      err_q         <= 1'b0;
      cache_wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (core_rd_en_i) begin
            addr_q        <= core_addr_i;
            blk_q         <= core_addr_i & ALIGN_MASK;
            cache_rd_en_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (cache_rd_en_q) begin
            cache_rd_en_q <= 1'b0;
          end else if (cache_rd_valid_i) begin
            rdata_q   <= cache_rd_data_i;
            rvalid_q  <= 1'b1;
            hit_cnt_q <= hit_cnt_d;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else if (cache_miss_i) begin
            miss_cnt_q      <= miss_cnt_d;
            mem_req_valid_q <= 1'b1;
            state_q         <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            tcnt_q          <= '0;
            state_q         <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (mem_resp_valid_i) begin
            fill_q        <= mem_resp_data_i;
            rdata_q       <= mem_resp_data_i;
            cache_wr_en_q <= 1'b1;
            rvalid_q      <= 1'b1;
            state_q       <= S_FILL;
          end else if (tcnt_q == TCNT_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        S_FILL: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign core_busy_o     = busy_q;
  assign core_rvalid_o   = rvalid_q;
  assign core_rdata_o    = rdata_q;
  assign core_err_o      = err_q;
  assign cache_rd_en_o   = cache_rd_en_q;
  assign cache_rd_addr_o = addr_q;
  assign cache_wr_en_o   = cache_wr_en_q;
  assign cache_wr_addr_o = blk_q;
  assign cache_wr_data_o = fill_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = blk_q;
  assign hit_cnt_o       = hit_cnt_q;
  assign miss_cnt_o      = miss_cnt_q;

endmodule
